// File: rtl/plab4_net_router_input_unit_tp_pkg.sv
// plab4_net_router_input_unit_tp_pkg: ring port indices and message field positions
package plab4_net_router_input_unit_tp_pkg;
    localparam int WEST = 0;
    localparam int TERM = 1;
    localparam int EAST = 2;

    function automatic int dest_msb(input int msg_nbits);
        return msg_nbits - 1;
    endfunction

    function automatic int tag_pos(input int msg_nbits, input int num_routers);
        return msg_nbits - 1 - $clog2(num_routers);
    endfunction
endpackage

// File: rtl/plab4_net_router_route_calc.sv
// plab4_net_router_route_calc: one-hot shortest-path route, ties at half the ring go east
module plab4_net_router_route_calc
    import plab4_net_router_input_unit_tp_pkg::*;
#(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 8
) (
    input  logic [$clog2(p_num_routers)-1:0] dest,
    output logic [2:0]                       reqs
);
    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam logic [c_dest_nbits-1:0] c_id   = c_dest_nbits'(p_router_id);
    localparam logic [c_dest_nbits-1:0] c_half = c_dest_nbits'(p_num_routers / 2);

    logic [c_dest_nbits-1:0] d;

    // power-of-two ring size makes the subtraction wrap modulo the ring
    assign d    = dest - c_id;
    assign reqs = 3'b001 << ((d == '0) ? TERM : (d <= c_half) ? EAST : WEST);
endmodule

// File: rtl/plab4_net_router_input_unit_tp.sv
// plab4_net_router_input_unit_tp: input FIFO with route request and cross-domain drop filter
module plab4_net_router_input_unit_tp
    import plab4_net_router_input_unit_tp_pkg::*;
#(
    parameter int   p_router_id   = 0,
    parameter int   p_num_routers = 8,
    parameter int   p_msg_nbits   = 32,
    parameter int   p_num_entries = 2,
    parameter logic domain        = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic [2:0]             reqs,
    input  logic [2:0]             grants,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [7:0]             drop_count
);
    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam int c_ptr_nbits  = $clog2(p_num_entries);
    localparam int c_cnt_nbits  = $clog2(p_num_entries + 1);
    localparam int c_tag_pos    = tag_pos(p_msg_nbits, p_num_routers);
    localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_num_entries - 1);
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [c_ptr_nbits-1:0] head, tail;
    logic [c_cnt_nbits-1:0] count;
    logic [2:0]             route;
    logic                   empty, xfer, drop, wr, deq;

    assign empty   = count == '0;
    assign in_rdy  = count != c_full;
    assign xfer    = in_val && in_rdy;
    assign drop    = xfer && (in_msg[c_tag_pos] != domain);
    assign wr      = xfer && !drop;
    assign out_msg = empty ? '0 : mem[head];
    assign reqs    = empty ? 3'b000 : route;
    assign deq     = |(reqs & grants);

    plab4_net_router_route_calc #(
        .p_router_id   (p_router_id),
        .p_num_routers (p_num_routers)
    ) route_calc (
        .dest (out_msg[dest_msb(p_msg_nbits) -: c_dest_nbits]),
        .reqs (route)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (wr) tail <= (tail == c_last) ? '0 : tail + 1'b1;
            if (deq) head <= (head == c_last) ? '0 : head + 1'b1;
            if (wr != deq) count <= wr ? count + 1'b1 : count - 1'b1;
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
        end
    end

    // storage needs no reset: out_msg is masked while the FIFO is empty
    always_ff @(posedge clk)
        if (wr) mem[tail] <= in_msg;
endmodule

// File: tb/tb_plab4_net_router_input_unit_tp.sv
// tb_plab4_net_router_input_unit_tp: directed checks of routing, backpressure, filtering and reset
module tb_plab4_net_router_input_unit_tp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        a_val = 1'b0, a_rdy;
    logic [31:0] a_msg = '0, a_out;
    logic [2:0]  a_reqs, a_grants = '0;
    logic [7:0]  a_drop;
    logic        b_val = 1'b0, b_rdy;
    logic [31:0] b_msg = '0, b_out;
    logic [2:0]  b_reqs, b_grants = '0;
    logic [7:0]  b_drop;
    logic        c_val = 1'b0, c_rdy;
    logic [31:0] c_msg = '0, c_out;
    logic [2:0]  c_reqs, c_grants = '0;
    logic [7:0]  c_drop;

    always #5 clk = ~clk;

    plab4_net_router_input_unit_tp #(.p_router_id(3), .domain(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_val(a_val), .in_rdy(a_rdy), .in_msg(a_msg),
        .reqs(a_reqs), .grants(a_grants), .out_msg(a_out), .drop_count(a_drop));
    plab4_net_router_input_unit_tp #(.p_router_id(0), .domain(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_val(b_val), .in_rdy(b_rdy), .in_msg(b_msg),
        .reqs(b_reqs), .grants(b_grants), .out_msg(b_out), .drop_count(b_drop));
    plab4_net_router_input_unit_tp #(.p_router_id(0), .domain(1'b1)) dut_c (
        .clk(clk), .reset(reset), .in_val(c_val), .in_rdy(c_rdy), .in_msg(c_msg),
        .reqs(c_reqs), .grants(c_grants), .out_msg(c_out), .drop_count(c_drop));

    function automatic logic [31:0] mk(input logic [2:0] dest, input logic tag, input logic [27:0] pl);
        return {dest, tag, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", a_rdy); end
        checks++; if (a_reqs !== 3'b000) begin errors++; $display("FAIL reset_reqs: got %b expected 000", a_reqs); end
        checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", a_out); end
        checks++; if (a_drop !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", a_drop); end
        reset = 1'b0;
        tick();
        checks++; if ({b_reqs, c_reqs} !== 6'b0) begin errors++; $display("FAIL reset_reqs_bc: got %b expected 0", {b_reqs, c_reqs}); end
    endtask

    task automatic test_terminal();
        logic [31:0] m;
        m = mk(3'd3, 1'b0, 28'h123);
        a_val = 1'b1;
        a_msg = m;
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL term_rdy: got %b expected 1", a_rdy); end
        checks++; if (a_reqs !== 3'b000) begin errors++; $display("FAIL term_no_bypass: got %b expected 000", a_reqs); end
        tick();
        a_val = 1'b0;
        checks++; if (a_reqs !== 3'b010) begin errors++; $display("FAIL term_reqs: got %b expected 010", a_reqs); end
        checks++; if (a_out !== m) begin errors++; $display("FAIL term_out: got %h expected %h", a_out, m); end
        a_grants = 3'b010;
        tick();
        a_grants = 3'b000;
        checks++; if (a_reqs !== 3'b000) begin errors++; $display("FAIL term_deq: got %b expected 000", a_reqs); end
    endtask

    task automatic test_route();
        logic [2:0] dst [7] = '{3'd2, 3'd6, 3'd4, 3'd0, 3'd7, 3'd1, 3'd5};
        logic [2:0] exp [7] = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001};
        for (int i = 0; i < 7; i++) begin
            b_val = 1'b1;
            b_msg = mk(dst[i], 1'b0, 28'(i));
            tick();
            b_val = 1'b0;
            checks++; if (b_reqs !== exp[i]) begin errors++; $display("FAIL route_dest%0d: got %b expected %b", dst[i], b_reqs, exp[i]); end
            b_grants = ~exp[i];
            tick();
            checks++; if (b_reqs !== exp[i]) begin errors++; $display("FAIL route_wrong_grant%0d: got %b expected %b", dst[i], b_reqs, exp[i]); end
            b_grants = 3'b111;
            tick();
            b_grants = 3'b000;
            checks++; if (b_reqs !== 3'b000) begin errors++; $display("FAIL route_deq%0d: got %b expected 000", dst[i], b_reqs); end
        end
    endtask

    task automatic test_full();
        logic [31:0] m [3];
        for (int k = 0; k < 3; k++) m[k] = mk(3'd2, 1'b0, 28'hA0 + 28'(k));
        b_val = 1'b1;
        b_msg = m[0];
        checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy0: got %b expected 1", b_rdy); end
        tick();
        b_msg = m[1];
        checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy1: got %b expected 1", b_rdy); end
        tick();
        b_msg = m[2];
        checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy2: got %b expected 0", b_rdy); end
        tick();
        checks++; if (b_out !== m[0]) begin errors++; $display("FAIL full_head0: got %h expected %h", b_out, m[0]); end
        b_grants = 3'b100;
        #1;
        checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_grant: got %b expected 0", b_rdy); end
        tick();
        b_grants = 3'b000;
        checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after: got %b expected 1", b_rdy); end
        checks++; if (b_out !== m[1]) begin errors++; $display("FAIL full_head1: got %h expected %h", b_out, m[1]); end
        tick();
        b_val = 1'b0;
        checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL full_refill: got %b expected 0", b_rdy); end
        b_grants = 3'b100;
        tick();
        checks++; if (b_out !== m[2]) begin errors++; $display("FAIL full_head2: got %h expected %h", b_out, m[2]); end
        tick();
        b_grants = 3'b000;
        checks++; if (b_reqs !== 3'b000 || b_rdy !== 1'b1) begin errors++; $display("FAIL full_drain: got reqs %b rdy %b expected 000 1", b_reqs, b_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s [7];
        for (int k = 0; k < 7; k++) s[k] = mk(3'd2, 1'b0, 28'h50 + 28'(k));
        b_val = 1'b1;
        b_msg = s[0];
        tick();
        for (int i = 1; i < 7; i++) begin
            b_msg = s[i];
            b_grants = 3'b100;
            checks++; if (b_out !== s[i-1]) begin errors++; $display("FAIL b2b_out%0d: got %h expected %h", i, b_out, s[i-1]); end
            checks++; if (b_reqs !== 3'b100 || b_rdy !== 1'b1) begin errors++; $display("FAIL b2b_state%0d: got reqs %b rdy %b expected 100 1", i, b_reqs, b_rdy); end
            tick();
        end
        b_val = 1'b0;
        checks++; if (b_out !== s[6]) begin errors++; $display("FAIL b2b_last: got %h expected %h", b_out, s[6]); end
        tick();
        b_grants = 3'b000;
        checks++; if (b_reqs !== 3'b000) begin errors++; $display("FAIL b2b_empty: got %b expected 000", b_reqs); end
    endtask

    task automatic test_domain();
        logic [31:0] m;
        c_val = 1'b1;
        c_msg = mk(3'd2, 1'b0, 28'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (c_reqs !== 3'b000) begin errors++; $display("FAIL dom_reqs%0d: got %b expected 000", k, c_reqs); end
        end
        checks++; if (c_drop !== 8'd3) begin errors++; $display("FAIL dom_drop3: got %0d expected 3", c_drop); end
        repeat (251) tick();
        checks++; if (c_drop !== 8'd254) begin errors++; $display("FAIL dom_drop254: got %0d expected 254", c_drop); end
        repeat (6) tick();
        checks++; if (c_drop !== 8'd255) begin errors++; $display("FAIL dom_drop_sat: got %0d expected 255", c_drop); end
        m = mk(3'd2, 1'b1, 28'h77);
        c_msg = m;
        tick();
        c_val = 1'b0;
        checks++; if (c_reqs !== 3'b100 || c_out !== m) begin errors++; $display("FAIL dom_accept: got reqs %b out %h expected 100 %h", c_reqs, c_out, m); end
    endtask

    task automatic test_mid_reset();
        a_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_msg = mk(3'd3, 1'b1, 28'(k));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            a_msg = mk(3'd3, 1'b0, 28'h10 + 28'(k));
            tick();
        end
        a_val = 1'b0;
        checks++; if (a_drop !== 8'd5 || a_rdy !== 1'b0 || a_reqs !== 3'b010) begin errors++; $display("FAIL mid_setup: got drop %0d rdy %b reqs %b expected 5 0 010", a_drop, a_rdy, a_reqs); end
        reset = 1'b1;
        #1;
        checks++; if (a_reqs !== 3'b000) begin errors++; $display("FAIL mid_reqs: got %b expected 000", a_reqs); end
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b expected 1", a_rdy); end
        checks++; if (a_drop !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d expected 0", a_drop); end
        #2;
        reset = 1'b0;
        tick();
        checks++; if (a_reqs !== 3'b000) begin errors++; $display("FAIL mid_after1: got %b expected 000", a_reqs); end
        tick();
        checks++; if (a_reqs !== 3'b000 || a_rdy !== 1'b1) begin errors++; $display("FAIL mid_after2: got reqs %b rdy %b expected 000 1", a_reqs, a_rdy); end
    endtask

    initial begin
        test_reset();
        test_terminal();
        test_route();
        test_full();
        test_back_to_back();
        test_domain();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
